ts_scan_ctrl: RTL and testbench

Scan controller for the on-die temperature sensors. It sequences reads of up to four sensors over one shared request/acknowledge read port and keeps the latest reading of each. After each full scan it selects the hottest sensor with ±TH hysteresis, so the selection does not chatter between sensors of nearly equal temperature. It also drives a hysteretic over-temperature alarm. It sits between the sensor read mux and the thermal-management logic that consumes `hot_idx`, `hot_val` and `alarm`.

---
 rtl/ts_scan_ctrl_pkg.sv | 27 ++
 rtl/ts_max_sel.sv | 42 ++++
 rtl/ts_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ts_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ts_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ts_scan_ctrl_pkg
// Shared definitions for the temperature-sensor scan controller and the
// sensor comparators: scan FSM state encoding, default thresholds/timing
// and the reading type.
// ---------------------------------------------------------------------------
package ts_scan_ctrl_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

    // Default reading width and thresholds
    localparam int TS_W        = 8;
    localparam int TS_TH       = 10;
    localparam int TS_GAP      = 16;
    localparam int TS_TO       = 15;
    localparam int TS_ALARM_HI = 200;

    // One unsigned sensor reading
    typedef logic [TS_W-1:0] ts_reading_t;

endpackage

// File: rtl/ts_max_sel.sv
// ---------------------------------------------------------------------------
// ts_max_sel
// Combinational argmax over NS sensor readings. Sensors whose mask bit is set
// (faulted) are excluded. On equal readings the lowest index wins.
// Ports:
//   rdg     - packed readings, rdg[i] is sensor i
//   mask    - per-sensor exclude flag (1 = faulted)
//   cand    - index of the largest non-excluded reading (0 if none)
//   all_flt - every sensor is excluded
// ---------------------------------------------------------------------------
module ts_max_sel
    import ts_scan_ctrl_pkg::*;
#(
    parameter int NS = 4,
    parameter int W  = TS_W
) (
    input  logic [NS-1:0][W-1:0] rdg,
    input  logic [NS-1:0]        mask,
    output logic [1:0]           cand,
    output logic                 all_flt
);

    logic [W-1:0] best_s;
    logic         found_s;
    logic         take_s;

    // Linear scan; strict '>' keeps the earliest index on ties
    always_comb begin
        cand    = 2'd0;
        best_s  = '0;
        found_s = 1'b0;
        take_s  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            take_s  = !mask[i] && (!found_s || (rdg[i] > best_s));
            cand    = take_s ? 2'(i) : cand;
            best_s  = take_s ? rdg[i] : best_s;
            found_s = found_s | take_s;
        end
        all_flt = &mask;
    end

endmodule

// File: rtl/ts_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ts_scan_ctrl
// Periodically reads up to four temperature sensors over a shared
// request/acknowledge port, keeps the latest reading of each, and after each
// full scan selects the hottest sensor (with hysteresis) and updates a
// hysteretic over-temperature alarm.
// Ports:
//   clk, rst       - clock; synchronous active-low reset
//   en             - scan enable, looked at only while idle
//   rd_req/rd_sel  - read request and sensor index, held stable while waiting
//   rd_ack/rd_data - read completion and its data (same cycle)
//   hot_idx/hot_val- selected hottest sensor and its stored reading
//   alarm          - over-temperature flag
//   fault          - per-sensor timeout flags from the latest scan
//   scan_done      - one-cycle pulse after each end-of-scan update
// ---------------------------------------------------------------------------
module ts_scan_ctrl
    import ts_scan_ctrl_pkg::*;
#(
    parameter int NS       = 4,
    parameter int W        = TS_W,
    parameter int TH       = TS_TH,
    parameter int GAP      = TS_GAP,
    parameter int TO       = TS_TO,
    parameter int ALARM_HI = TS_ALARM_HI
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          rd_req,
    output logic [1:0]    rd_sel,
    input  logic          rd_ack,
    input  logic [W-1:0]  rd_data,
    output logic [1:0]    hot_idx,
    output logic [W-1:0]  hot_val,
    output logic          alarm,
    output logic [NS-1:0] fault,
    output logic          scan_done
);

    localparam int GW = $clog2(GAP + 1);
    localparam int TW = (TO > 1) ? $clog2(TO) : 1;

    localparam logic [GW-1:0] GAP_M1   = GW'(GAP - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP);
    localparam logic [TW-1:0] TO_M1    = TW'(TO - 1);
    localparam logic [1:0]    IDX_LAST = 2'(NS - 1);
    // Comparisons are made one bit wider so reading+TH cannot wrap
    localparam logic [W:0]    TH_W1    = (W+1)'(TH);
    localparam logic [W:0]    ALM_SET  = (W+1)'(ALARM_HI);
    localparam logic [W:0]    ALM_CLR  = (W+1)'(ALARM_HI - TH);

    scan_state_t           state_r, state_n;
    logic [GW-1:0]         gap_r, gap_n;
    logic [TW-1:0]         wait_r, wait_n;
    logic [1:0]            idx_r, idx_n;
    logic                  ack_s, to_s, done_s;

    logic [NS-1:0][W-1:0]  rdg_r;
    logic [NS-1:0]         fault_r;
    logic [1:0]            hot_idx_r, hot_idx_n;
    logic [W-1:0]          hot_val_r, hot_val_n;
    logic                  alarm_r, alarm_n;
    logic                  rd_req_r;
    logic                  scan_done_r;

    logic [1:0]            cand_s;
    logic                  all_flt_s;

    ts_max_sel #(
        .NS (NS),
        .W  (W)
    ) u_max_sel (
        .rdg     (rdg_r),
        .mask    (fault_r),
        .cand    (cand_s),
        .all_flt (all_flt_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state, counters and per-cycle strobes
    always_comb begin
        state_n = state_r;
        gap_n   = gap_r;
        wait_n  = wait_r;
        idx_n   = idx_r;
        ack_s   = 1'b0;
        to_s    = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wait_n = '0;
                // Saturate at GAP so a late 'en' starts immediately
                gap_n  = (gap_r == GAP_MAX) ? gap_r : gap_r + GW'(1);
                if (en && (gap_r >= GAP_M1)) begin
                    state_n = ST_REQ;
                    idx_n   = 2'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    ack_s   = 1'b1;
                    state_n = ST_UPD;
                end else if (wait_r == TO_M1) begin
                    to_s    = 1'b1;
                    state_n = ST_UPD;
                end else begin
                    wait_n  = wait_r + TW'(1);
                end
            end
            ST_UPD: begin
                wait_n = '0;
                if (idx_r < IDX_LAST) begin
                    idx_n   = idx_r + 2'd1;
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                gap_n   = '0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // End-of-scan hot-sensor selection and alarm hysteresis
    always_comb begin
        hot_idx_n = hot_idx_r;
        hot_val_n = hot_val_r;
        alarm_n   = alarm_r;
        if (all_flt_s) begin
            alarm_n = 1'b1;
        end else begin
            if (fault_r[hot_idx_r]) begin
                hot_idx_n = cand_s;
            end else if ({1'b0, rdg_r[cand_s]} > ({1'b0, rdg_r[hot_idx_r]} + TH_W1)) begin
                hot_idx_n = cand_s;
            end else begin
                hot_idx_n = hot_idx_r;
            end
            hot_val_n = rdg_r[hot_idx_n];
            if ({1'b0, hot_val_n} >= ALM_SET) begin
                alarm_n = 1'b1;
            end else if ({1'b0, hot_val_n} < ALM_CLR) begin
                alarm_n = 1'b0;
            end else begin
                alarm_n = alarm_r;
            end
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            gap_r       <= '0;
            wait_r      <= '0;
            idx_r       <= 2'd0;
            rdg_r       <= '0;
            fault_r     <= '0;
            hot_idx_r   <= 2'd0;
            hot_val_r   <= '0;
            alarm_r     <= 1'b0;
            rd_req_r    <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            gap_r       <= gap_n;
            wait_r      <= wait_n;
            idx_r       <= idx_n;
            rd_req_r    <= (state_n == ST_REQ);
            scan_done_r <= done_s;
            if (ack_s) begin
                rdg_r[idx_r]   <= rd_data;
                fault_r[idx_r] <= 1'b0;
            end
            if (to_s) begin
                fault_r[idx_r] <= 1'b1;
            end
            if (done_s) begin
                hot_idx_r <= hot_idx_n;
                hot_val_r <= hot_val_n;
                alarm_r   <= alarm_n;
            end
        end
    end

    assign rd_req    = rd_req_r;
    assign rd_sel    = idx_r;
    assign hot_idx   = hot_idx_r;
    assign hot_val   = hot_val_r;
    assign alarm     = alarm_r;
    assign fault     = fault_r;
    assign scan_done = scan_done_r;

endmodule

// File: tb/tb_ts_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ts_scan_ctrl
// Directed bench for ts_scan_ctrl (default parameters): a scripted sensor
// port answers each request, and every scan result is compared with values
// worked out by hand in the scan table below.
// ---------------------------------------------------------------------------
module tb_ts_scan_ctrl;

    localparam int GAP = 16;
    localparam int TO  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data = 8'd0;
    logic       rd_req;
    logic [1:0] rd_sel;
    logic [1:0] hot_idx;
    logic [7:0] hot_val;
    logic       alarm;
    logic [3:0] fault;
    logic       scan_done;

    int total = 0;
    int bad   = 0;
    int scan_no = 0;

    ts_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .hot_idx   (hot_idx),
        .hot_val   (hot_val),
        .alarm     (alarm),
        .fault     (fault),
        .scan_done (scan_done)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (scan %0d): got=%0d exp=%0d", tag, scan_no, got, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!rd_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = rd_req;
        if (!ok) check("req_wait", 32'd0, 32'd1);
    endtask

    // One full scan: per sensor either ack after one wait cycle or never ack
    task automatic scan(input logic [7:0] v0, input logic [7:0] v1,
                        input logic [7:0] v2, input logic [7:0] v3,
                        input logic [3:0] noack,
                        input logic [1:0] e_hot, input logic [7:0] e_val,
                        input logic e_alm, input logic [3:0] e_flt);
        logic [7:0] v [4];
        bit ok;
        int n;
        scan_no++;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int s = 0; s < 4; s++) begin
            wait_req(ok);
            if (!ok) return;
            check("rd_sel", 32'(rd_sel), 32'(s));
            if (noack[s]) begin
                n = 1;
                @(negedge clk);
                while (rd_req && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                check("to_len", 32'(n), 32'(TO));
            end else begin
                @(negedge clk);
                rd_ack  = 1'b1;
                rd_data = v[s];
                @(posedge clk);
                #1;
                rd_ack  = 1'b0;
                rd_data = 8'd0;
                @(negedge clk);
                check("req_drop", 32'(rd_req), 32'd0);
            end
        end
        n = 0;
        while (!scan_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scan_done", 32'(scan_done), 32'd1);
        check("hot_idx", 32'(hot_idx), 32'(e_hot));
        check("hot_val", 32'(hot_val), 32'(e_val));
        check("alarm", 32'(alarm), 32'(e_alm));
        check("fault", 32'(fault), 32'(e_flt));
        @(negedge clk);
        check("done_pulse", 32'(scan_done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
        check({tag, "_hot_idx"}, 32'(hot_idx), 32'd0);
        check({tag, "_hot_val"}, 32'(hot_val), 32'd0);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    endtask

    initial begin
        int n;
        bit ok;
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Release reset; first request must come GAP cycles later.
        // A stray ack in IDLE must change nothing.
        rst = 1'b1;
        n = 0;
        while (!rd_req && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                rd_ack  = 1'b1;
                rd_data = 8'hAA;
            end else begin
                rd_ack  = 1'b0;
                rd_data = 8'd0;
            end
            if (n == 6) begin
                check("idle_ack_hot_val", 32'(hot_val), 32'd0);
                check("idle_ack_fault", 32'(fault), 32'd0);
                check("idle_ack_rd_req", 32'(rd_req), 32'd0);
            end
        end
        check("gap_len", 32'(n), 32'(GAP));

        //    v0     v1     v2     v3     noack    hot   val     alm   fault
        scan(8'd50, 8'd60, 8'd70, 8'd80, 4'b0000, 2'd3, 8'd80,  1'b0, 4'b0000); // basic
        scan(8'd50, 8'd88, 8'd70, 8'd80, 4'b0000, 2'd3, 8'd80,  1'b0, 4'b0000); // 88 <= 90: hold
        scan(8'd50, 8'd91, 8'd70, 8'd80, 4'b0000, 2'd1, 8'd91,  1'b0, 4'b0000); // 91 > 90: switch
        scan(8'd255,8'd255,8'd255,8'd255,4'b0000, 2'd1, 8'd255, 1'b1, 4'b0000); // no wrap of 255+TH
        scan(8'd255,8'd255,8'd255,8'd255,4'b0000, 2'd1, 8'd255, 1'b1, 4'b0000);
        scan(8'd10, 8'd100,8'd10, 8'd10, 4'b0000, 2'd1, 8'd100, 1'b0, 4'b0000); // alarm clears
        scan(8'd10, 8'd199,8'd10, 8'd10, 4'b0000, 2'd1, 8'd199, 1'b0, 4'b0000); // alarm 0
        scan(8'd10, 8'd200,8'd10, 8'd10, 4'b0000, 2'd1, 8'd200, 1'b1, 4'b0000); // alarm 1
        scan(8'd10, 8'd195,8'd10, 8'd10, 4'b0000, 2'd1, 8'd195, 1'b1, 4'b0000); // alarm held
        scan(8'd10, 8'd189,8'd10, 8'd10, 4'b0000, 2'd1, 8'd189, 1'b0, 4'b0000); // alarm 0
        scan(8'd10, 8'd20, 8'd150,8'd10, 4'b0000, 2'd2, 8'd150, 1'b0, 4'b0000); // sensor 2 hot
        scan(8'd40, 8'd30, 8'd0,  8'd40, 4'b0100, 2'd0, 8'd40,  1'b0, 4'b0100); // hot times out; tie -> 0
        scan(8'd40, 8'd30, 8'd5,  8'd40, 4'b0000, 2'd0, 8'd40,  1'b0, 4'b0000); // fault cleared
        scan(8'd0,  8'd0,  8'd0,  8'd0,  4'b1111, 2'd0, 8'd40,  1'b1, 4'b1111); // all faulted

        // Reset asserted in the middle of a handshake with an ack pending
        wait_req(ok);
        rst     = 1'b0;
        rd_ack  = 1'b1;
        rd_data = 8'h77;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst     = 1'b1;
        rd_ack  = 1'b0;
        rd_data = 8'd0;

        // First scan after reset, all equal: lowest index
        scan(8'd255,8'd255,8'd255,8'd255,4'b0000, 2'd0, 8'd255, 1'b1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
